// File: rtl/code_lock_pkg.sv
// Shared types and constants for the code lock and its button front end.
package code_lock_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        OPEN,
        ERROR,
        LOCKOUT
    } state_t;

endpackage

// File: rtl/enter_sync.sv
// Button front end: metastability synchroniser plus rising-edge detector.
// Produces a registered one-clk pulse per press, however long it is held.
module enter_sync
    import code_lock_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic enter,
    output logic enter_p
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronise the raw button, remember last level, register the rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            enter_p <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], enter};
            prev_q  <= sync_q[SYNC_STAGES-1];
            enter_p <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/code_lock_seq.sv
// Sequential code lock: collects CODE_LEN digits, opens on a full match,
// blinks an error on mismatch and locks out after MAX_TRIES failures.
// Optional feature macro: CODE_LOCK_PROG_EN adds the prog port and a
// reprogrammable code register, written digit by digit while OPEN.
module code_lock_seq
    import code_lock_pkg::*;
#(
    parameter int unsigned                KEY_W       = 2,
    parameter int unsigned                CODE_LEN    = 4,
    parameter logic [CODE_LEN*KEY_W-1:0]  CODE        = {2'd3, 2'd1, 2'd2, 2'd0},
    parameter int unsigned                MAX_TRIES   = 3,
    parameter int unsigned                OPEN_TICKS  = 8,
    parameter int unsigned                ERR_TICKS   = 4,
    parameter int unsigned                LOCK_TICKS  = 16,
    parameter int unsigned                BLINK_TICKS = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tick,
    input  logic                            enter,
    input  logic [KEY_W-1:0]                key,
`ifdef CODE_LOCK_PROG_EN
    input  logic                            prog,
`endif
    output logic                            open,
    output logic                            error,
    output logic                            locked,
    output logic                            led,
    output logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt
);

    localparam int unsigned IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned FCNT_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMAX   = (OPEN_TICKS > ERR_TICKS)
                                   ? ((OPEN_TICKS > LOCK_TICKS) ? OPEN_TICKS : LOCK_TICKS)
                                   : ((ERR_TICKS  > LOCK_TICKS) ? ERR_TICKS  : LOCK_TICKS);
    localparam int unsigned TCNT_W = $clog2(TMAX + 1);
    localparam int unsigned BCNT_W = $clog2(BLINK_TICKS + 1);

    localparam logic [TCNT_W-1:0] OPEN_LIM  = TCNT_W'(OPEN_TICKS - 1);
    localparam logic [TCNT_W-1:0] ERR_LIM   = TCNT_W'(ERR_TICKS - 1);
    localparam logic [TCNT_W-1:0] LOCK_LIM  = TCNT_W'(LOCK_TICKS - 1);
    localparam logic [BCNT_W-1:0] BLINK_LIM = BCNT_W'(BLINK_TICKS - 1);

    typedef logic [CODE_LEN-1:0][KEY_W-1:0] code_t;

    state_t              state;
    logic                enter_p;
    logic                mismatch;
    logic [FCNT_W-1:0]   fail_cnt;
    logic [TCNT_W-1:0]   tick_cnt;
    logic [BCNT_W-1:0]   blink_cnt;
    code_t               code_q;
    logic [IDX_W-1:0]    dig_idx;
    logic                digit_miss;
    logic                last_digit;
    logic [TCNT_W-1:0]   alarm_lim;

`ifdef CODE_LOCK_PROG_EN
    code_t               code_stage;
    code_t               code_wr;
    logic [IDX_W-1:0]    prog_idx;
    logic                prog_act;
`endif

    enter_sync u_enter_sync (
        .clk     (clk),
        .rst     (rst),
        .enter   (enter),
        .enter_p (enter_p)
    );

`ifdef CODE_LOCK_PROG_EN
    // Staged code with the current key dropped into the slot being programmed
    always_comb begin
        code_wr           = code_stage;
        code_wr[prog_idx] = key;
    end
`else
    assign code_q = code_t'(CODE);
`endif

    assign dig_idx    = IDX_W'(digit_cnt);
    assign digit_miss = (key != code_q[dig_idx]);
    assign last_digit = (digit_cnt == ($clog2(CODE_LEN+1))'(CODE_LEN - 1));
    assign alarm_lim  = (state == LOCKOUT) ? LOCK_LIM : ERR_LIM;

    // Lock FSM with tick timer, blink toggle and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            open      <= 1'b0;
            error     <= 1'b0;
            locked    <= 1'b0;
            led       <= 1'b0;
            digit_cnt <= '0;
            mismatch  <= 1'b0;
            fail_cnt  <= '0;
            tick_cnt  <= '0;
            blink_cnt <= '0;
`ifdef CODE_LOCK_PROG_EN
            code_q     <= code_t'(CODE);
            code_stage <= code_t'(CODE);
            prog_idx   <= '0;
            prog_act   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, COLLECT: begin
                    if (enter_p) begin
                        if (last_digit) begin
                            digit_cnt <= '0;
                            mismatch  <= 1'b0;
                            tick_cnt  <= '0;
                            blink_cnt <= '0;
                            if (!(mismatch || digit_miss)) begin
                                state    <= OPEN;
                                open     <= 1'b1;
                                fail_cnt <= '0;
                            end else begin
                                fail_cnt <= fail_cnt + FCNT_W'(1);
                                error    <= 1'b1;
                                led      <= 1'b1;
                                if (fail_cnt == FCNT_W'(MAX_TRIES - 1)) begin
                                    state  <= LOCKOUT;
                                    locked <= 1'b1;
                                end else begin
                                    state  <= ERROR;
                                end
                            end
                        end else begin
                            state     <= COLLECT;
                            digit_cnt <= digit_cnt + ($clog2(CODE_LEN+1))'(1);
                            mismatch  <= mismatch | digit_miss;
                        end
                    end
                end

                OPEN: begin
`ifdef CODE_LOCK_PROG_EN
                    if (prog_act && !prog) begin
                        // Programming abandoned: drop staged digits, keep old code
                        state    <= IDLE;
                        open     <= 1'b0;
                        tick_cnt <= '0;
                        prog_act <= 1'b0;
                        prog_idx <= '0;
                    end else if (prog) begin
                        prog_act <= 1'b1;
                        if (enter_p) begin
                            code_stage <= code_wr;
                            if (prog_idx == IDX_W'(CODE_LEN - 1)) begin
                                code_q   <= code_wr;
                                state    <= IDLE;
                                open     <= 1'b0;
                                tick_cnt <= '0;
                                prog_act <= 1'b0;
                                prog_idx <= '0;
                            end else begin
                                prog_idx <= prog_idx + IDX_W'(1);
                            end
                        end
                    end else
`endif
                    if (tick) begin
                        if (tick_cnt == OPEN_LIM) begin
                            state    <= IDLE;
                            open     <= 1'b0;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + TCNT_W'(1);
                        end
                    end
                end

                ERROR, LOCKOUT: begin
                    if (tick) begin
                        if (tick_cnt == alarm_lim) begin
                            if (state == LOCKOUT) begin
                                fail_cnt <= '0;
                            end
                            state     <= IDLE;
                            error     <= 1'b0;
                            locked    <= 1'b0;
                            led       <= 1'b0;
                            tick_cnt  <= '0;
                            blink_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + TCNT_W'(1);
                            if (blink_cnt == BLINK_LIM) begin
                                blink_cnt <= '0;
                                led       <= ~led;
                            end else begin
                                blink_cnt <= blink_cnt + BCNT_W'(1);
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_lock_seq.sv
// Directed bench for code_lock_seq with default parameters.
// Tick strobe every 4 clks; window lengths measured by a tick monitor.
module tb_code_lock_seq;

    localparam logic [7:0] GOOD = {2'd3, 2'd1, 2'd2, 2'd0};
    localparam logic [7:0] BAD  = {2'd3, 2'd0, 2'd2, 2'd0};
    localparam logic [7:0] ONES = {2'd1, 2'd1, 2'd1, 2'd1};

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       tick  = 1'b0;
    logic       enter = 1'b0;
    logic [1:0] key   = 2'd0;
`ifdef CODE_LOCK_PROG_EN
    logic       prog  = 1'b0;
`endif
    logic       open;
    logic       error;
    logic       locked;
    logic       led;
    logic [2:0] digit_cnt;

    int checks = 0;
    int errors = 0;

    int open_ticks = 0;
    int err_ticks  = 0;
    int lock_ticks = 0;
    int led_chg    = 0;
    logic led_q    = 1'b0;

    int o0, e0, k0, l0;

    code_lock_seq dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .enter     (enter),
        .key       (key),
`ifdef CODE_LOCK_PROG_EN
        .prog      (prog),
`endif
        .open      (open),
        .error     (error),
        .locked    (locked),
        .led       (led),
        .digit_cnt (digit_cnt)
    );

    always #5 clk = ~clk;

    // Tick strobe, one clk wide every fourth clk
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            div  = (div + 1) % 4;
            tick = (div == 0);
        end
    end

    // Count ticks spent in each window and led level changes
    always @(posedge clk) begin
        if (open && tick)   open_ticks <= open_ticks + 1;
        if (error && !locked && tick) err_ticks <= err_ticks + 1;
        if (locked && tick) lock_ticks <= lock_ticks + 1;
        if (led !== led_q)  led_chg <= led_chg + 1;
        led_q <= led;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [1:0] k);
        @(negedge clk);
        key   = k;
        enter = 1'b1;
        repeat (5) @(negedge clk);
        enter = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic enter_code(input logic [7:0] c);
        for (int i = 0; i < 4; i++) press(c[2*i +: 2]);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((open || error || locked) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 1000), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_open",   open,      0);
        check("rst_error",  error,     0);
        check("rst_locked", locked,    0);
        check("rst_led",    led,       0);
        check("rst_digits", digit_cnt, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Correct code
        press(2'd0); check("good_d1", digit_cnt, 1);
        press(2'd2); check("good_d2", digit_cnt, 2);
        press(2'd1); check("good_d3", digit_cnt, 3);
        o0 = open_ticks;
        press(2'd3);
        check("good_open",   open,      1);
        check("good_digits", digit_cnt, 0);
        wait_idle("good_idle");
        check("good_window", open_ticks - o0, 8);
        check("good_closed", open, 0);

        // Wrong digit
        e0 = err_ticks;
        l0 = led_chg;
        enter_code(BAD);
        check("bad_error",  error,  1);
        check("bad_open",   open,   0);
        check("bad_locked", locked, 0);
        wait_idle("bad_idle");
        check("bad_window", err_ticks - e0, 4);
        check("bad_blinks", led_chg - l0, 4);
        check("bad_led_off", led, 0);
        enter_code(GOOD);
        check("retry_open", open, 1);
        wait_idle("retry_idle");

        // Lockout after three failures
        enter_code(BAD); check("lk_err1", error, 1); wait_idle("lk_idle1");
        enter_code(BAD); check("lk_err2", locked, 0); wait_idle("lk_idle2");
        k0 = lock_ticks;
        l0 = led_chg;
        enter_code(BAD);
        check("lk_locked", locked, 1);
        check("lk_error",  error,  1);
        press(2'd0);
        check("lk_ignored", digit_cnt, 0);
        check("lk_still",   locked,    1);
        wait_idle("lk_idle3");
        check("lk_window", lock_ticks - k0, 16);
        check("lk_blinks", led_chg - l0, 16);
        enter_code(GOOD);
        check("lk_reopen", open, 1);
        wait_idle("lk_reopen_idle");

        // Held button counts once
        @(negedge clk);
        key   = 2'd0;
        enter = 1'b1;
        repeat (200) @(negedge clk);
        check("hold_digits", digit_cnt, 1);
        enter = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_release", digit_cnt, 1);

        // Reset mid-attempt
        press(2'd2);
        check("mid_digits", digit_cnt, 2);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_digits", digit_cnt, 0);
        check("mid_rst_outs", {open, error, locked, led}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        enter_code(GOOD);
        check("mid_open", open, 1);
        wait_idle("mid_idle");

`ifdef CODE_LOCK_PROG_EN
        // Reprogram to 1,1,1,1
        enter_code(GOOD);
        check("prog_open", open, 1);
        prog = 1'b1;
        enter_code(ONES);
        check("prog_done", open, 0);
        check("prog_digits", digit_cnt, 0);
        prog = 1'b0;
        enter_code(GOOD);
        check("prog_old_err", error, 1);
        wait_idle("prog_old_idle");
        enter_code(ONES);
        check("prog_new_open", open, 1);
        wait_idle("prog_new_idle");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        enter_code(GOOD);
        check("prog_rst_open", open, 1);
        wait_idle("prog_rst_idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_lock_seq.md
# code_lock_seq

Parametrised successor to the two-key Moore lock. Accepts a sequence of `CODE_LEN` digits of `KEY_W` bits, each latched on a rising edge of an asynchronous `enter` button. Grants `open` for a timed window on a full match. On mismatch it flags `error` with a blinking `led`, and after `MAX_TRIES` consecutive failures it enters a timed lockout. Sits behind the existing clock divider, which supplies `tick`, and drives the panel LEDs and door actuator.

## Interface
- `KEY_W`, 2: digit width in bits.
- `CODE_LEN`, 4: number of digits per attempt, ≥1.
- `CODE`, `{2'd3,2'd1,2'd2,2'd0}`: reset code, `CODE_LEN*KEY_W` bits; digit 0 is in the LSBs and is entered first.
- `MAX_TRIES`, 3: consecutive failures before lockout, ≥1.
- `OPEN_TICKS`, 8: `open` window length, in ticks.
- `ERR_TICKS`, 4: `error` hold time, in ticks.
- `LOCK_TICKS`, 16: lockout length, in ticks.
- `BLINK_TICKS`, 1: ticks per `led` half-period.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `tick`, in, 1: one-`clk`-wide timebase strobe.
- `enter`, in, 1: raw asynchronous button.
- `key`, in, `KEY_W`: digit value, stable around `enter`.
- `prog`, in, 1: reprogram request (only when the macro is defined).
- `open`, out, 1: unlock.
- `error`, out, 1: last attempt failed.
- `locked`, out, 1: lockout active.
- `led`, out, 1: blinks while in ERROR.
- `digit_cnt`, out, `$clog2(CODE_LEN+1)`: digits accepted in the current attempt.

## Operation
- **Enter pulse:** `enter` passes through a 2-flop synchroniser and a rising-edge detector to form `enter_p`, one `clk` wide. Holding `enter` produces exactly one pulse.
- **Moore FSM states:** IDLE, COLLECT, OPEN, ERROR, LOCKOUT.
- **IDLE/COLLECT:**
  - Each `enter_p` compares `key` with code digit `digit_cnt`, sets a sticky `mismatch` bit on inequality, and increments `digit_cnt`. The first digit moves IDLE→COLLECT.
  - When the `CODE_LEN`-th digit is accepted: with no mismatch (including this digit), go to OPEN and clear `fail_cnt`; otherwise increment `fail_cnt` and go to ERROR, or to LOCKOUT if the new `fail_cnt` equals `MAX_TRIES`.
  - `digit_cnt` and `mismatch` clear on that transition.
- **OPEN:** `open`=1. After `OPEN_TICKS` ticks → IDLE.
- **ERROR:** `error`=1 and `led` toggles every `BLINK_TICKS` ticks, starting at 1. After `ERR_TICKS` ticks → IDLE with `led`=0.
- **LOCKOUT:** `locked`=1 and `error`=1 with `led` blinking. After `LOCK_TICKS` ticks → IDLE and `fail_cnt`=0.
- **Ignored pulses:** `enter_p` in OPEN, ERROR and LOCKOUT is ignored and not queued.
- **Reset values:** state IDLE; `open`/`error`/`locked`/`led`=0; `digit_cnt`=0; `fail_cnt`=0; code register = `CODE`.

## Timing
- `enter` rising before clk edge *n* produces `enter_p` high during cycle *n+2*. The digit is accepted at edge *n+3*, where `digit_cnt` updates.
- The state change after the final digit is visible at edge *n+3*; all outputs are registered from state and counters.
- **Tick counter:** cleared on every state entry. A `tick` coincident with the entry edge is not counted. The exit edge is the edge at which the count reaches the limit.
- Counter widths are `$clog2(max+1)`. No wrap occurs, because the exit happens at the limit.
- **`rst` mid-operation:** immediate return to reset values, including mid-attempt, and clears a lockout in progress.

## Configuration
- **`CODE_LOCK_PROG_EN` defined:** `prog` port and a writable code register exist.
  - In OPEN with `prog`=1, each `enter_p` writes `key` into code digit `prog_idx` and increments `prog_idx`. The OPEN timer is held while programming.
  - After `CODE_LEN` writes → IDLE with the new code active.
  - `prog` falling before completion → IDLE with the old code intact (staged writes discarded).
- **Undefined:** no `prog` port; the code is the constant `CODE`; `enter_p` in OPEN is ignored.

## Structure
- **Package `code_lock_pkg`:** `state_t` enum (IDLE, COLLECT, OPEN, ERROR, LOCKOUT) and the `SYNC_STAGES`=2 constant.
- **Sub-module `enter_sync`:** synchroniser plus edge detector (`clk`, `rst`, `enter` → `enter_p`), reusable for other buttons.
- FSM, tick counter, blink toggle and code register live in `code_lock_seq`.

## Test plan
- **Correct code:** defaults; digits 0,2,1,3 each via a 5-clk `enter` pulse → `open`=1 after the 4th digit, for exactly 8 ticks, then IDLE with `digit_cnt`=0.
- **Wrong digit:** digits 0,2,0,3 → `error`=1, `led` toggles each tick for 4 ticks, then IDLE; a following correct sequence opens.
- **Lockout:** three wrong attempts → `locked`=1 after the 3rd; `enter` during the 16 lockout ticks leaves `digit_cnt`=0; afterwards the correct code opens.
- **Held button:** `enter` held 200 clks with key=0 → `digit_cnt` goes 0→1 only.
- **Reset mid-attempt:** `rst` pulsed after 2 digits → `digit_cnt`=0, all outputs 0; a full correct sequence then opens.
- **`CODE_LOCK_PROG_EN`:** open, then `prog`=1 and write 1,1,1,1 → IDLE; old code now errors, 1,1,1,1 opens; `rst` restores `CODE`.
